// File: rtl/comp_pkg.sv
// Shared types and constants for the serial multi-word magnitude comparator.
package comp_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_FINISH
  } state_t;

  typedef logic [2:0] casc_t;

  localparam casc_t CASC_GT = 3'b100;
  localparam casc_t CASC_EQ = 3'b010;
  localparam casc_t CASC_LT = 3'b001;

endpackage : comp_pkg

// File: rtl/mod_comp_serial_if.sv
// Word-pair stream and verdict bundle between a requester and mod_comp_serial.
interface mod_comp_serial_if;
  import comp_pkg::*;

  logic              start_i;
  logic              valid_i;
  logic              last_i;
  logic [WORD_W-1:0] a_word_i;
  logic [WORD_W-1:0] b_word_i;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  logic              gt_o;
  logic              eq_o;
  logic              lt_o;

  modport master (
    output start_i, valid_i, last_i, a_word_i, b_word_i,
    input  busy_o, done_o, err_o, gt_o, eq_o, lt_o
  );

  modport slave (
    input  start_i, valid_i, last_i, a_word_i, b_word_i,
    output busy_o, done_o, err_o, gt_o, eq_o, lt_o
  );

endinterface : mod_comp_serial_if

// File: rtl/mod_comp16.sv
// 16-bit cascadable magnitude comparator: a differing word decides, an equal word
// passes the incoming cascade through.
module mod_comp16
  import comp_pkg::*;
(
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  input  logic              gt_i,
  input  logic              eq_i,
  input  logic              lt_i,
  output logic              gt_o,
  output logic              eq_o,
  output logic              lt_o
);

  always_comb begin
    {gt_o, eq_o, lt_o} = {gt_i, eq_i, lt_i};
    if (a_i > b_i) begin
      {gt_o, eq_o, lt_o} = CASC_GT;
    end else if (a_i < b_i) begin
      {gt_o, eq_o, lt_o} = CASC_LT;
    end
  end

endmodule : mod_comp16

// File: rtl/mod_comp_serial.sv
// Serial multi-word comparator: streams 16-bit word pairs LS-first through mod_comp16.
// Optional macro COMP_SIGNED_EN treats the LAST word as the two's-complement sign word.
module mod_comp_serial
  import comp_pkg::*;
#(
  parameter int unsigned MAX_WORDS = 4
) (
  input  logic             clk,
  input  logic             rst,
  mod_comp_serial_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(MAX_WORDS + 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  casc_t             casc_q, casc_d;
  casc_t             verdict_q, verdict_d;
  casc_t             slice_casc;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              full_c;
  logic [WORD_W-1:0] a_slice, b_slice;

  assign full_c = (cnt_q == CNT_W'(MAX_WORDS));

`ifdef COMP_SIGNED_EN
  // Flipping the sign bit of the top word maps two's complement onto unsigned order.
  assign a_slice = bus.last_i ? {~bus.a_word_i[WORD_W-1], bus.a_word_i[WORD_W-2:0]}
                              : bus.a_word_i;
  assign b_slice = bus.last_i ? {~bus.b_word_i[WORD_W-1], bus.b_word_i[WORD_W-2:0]}
                              : bus.b_word_i;
`else
  assign a_slice = bus.a_word_i;
  assign b_slice = bus.b_word_i;
`endif

  mod_comp16 u_slice (
    .a_i  (a_slice),
    .b_i  (b_slice),
    .gt_i (casc_q[2]),
    .eq_i (casc_q[1]),
    .lt_i (casc_q[0]),
    .gt_o (slice_casc[2]),
    .eq_o (slice_casc[1]),
    .lt_o (slice_casc[0])
  );

  // Next-state, counter, cascade and verdict update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    casc_d    = casc_q;
    verdict_d = verdict_q;
    done_d    = 1'b0;
    err_d     = err_q;

    if (bus.start_i) begin
      state_d = ST_ACCUM;
      cnt_d   = '0;
      casc_d  = CASC_EQ;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_ACCUM: begin
          if (bus.valid_i) begin
            if (full_c) begin
              // Word beyond capacity is dropped; finish on what was accepted.
              err_d     = 1'b1;
              verdict_d = casc_q;
              done_d    = 1'b1;
              state_d   = ST_FINISH;
            end else begin
              casc_d = slice_casc;
              cnt_d  = cnt_q + CNT_W'(1);
              if (bus.last_i) begin
                verdict_d = slice_casc;
                done_d    = 1'b1;
                state_d   = ST_FINISH;
              end
            end
          end
        end
        ST_FINISH: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d == ST_ACCUM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      casc_q    <= CASC_EQ;
      verdict_q <= CASC_EQ;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      casc_q    <= casc_d;
      verdict_q <= verdict_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
  assign bus.err_o  = err_q;
  assign bus.gt_o   = verdict_q[2];
  assign bus.eq_o   = verdict_q[1];
  assign bus.lt_o   = verdict_q[0];

endmodule : mod_comp_serial
